// File: rtl/nn_param_pkg.sv
// Shared definitions for the parameter shift loader: mode encodings,
// default word width and the (neuron, j) -> slot index mapping.
package nn_param_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_COMMIT = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  localparam int DATA_W_DEF = 8;

  // Each neuron owns N_INPUTS weights, then bias, then threshold.
  function automatic int slot_idx(input int neuron, input int j, input int n_inputs);
    return neuron * (n_inputs + 2) + j;
  endfunction

endpackage

// File: rtl/param_frame_counter.sv
// Saturating frame counter: tracks shadow fill level and derives
// load_done / in_ready combinationally from the count.
module param_frame_counter #(
  parameter int L     = 24,
  parameter int CNT_W = $clog2(L + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic load_done_o,
  output logic in_ready_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(L);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (inc_i && cnt_q != FULL)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign load_done_o = (cnt_q == FULL);
  assign in_ready_o  = (cnt_q <  FULL);

endmodule

// File: rtl/param_shift_loader.sv
// Shadow shift chain + active parameter bank with commit/clear protocol.
// Optional readback of the word leaving slot 0: define PARAM_READBACK_EN.
module param_shift_loader
  import nn_param_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 4,
  localparam int L        = N_NEURONS * (N_INPUTS + 2),
  localparam int CNT_W    = $clog2(L + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [L*DATA_W-1:0] params_o,
  output logic                load_done,
  output logic                commit_pulse,
  output logic                err,
  output logic [DATA_W-1:0]   rb_data,
  output logic                rb_valid
);

  logic [L-1:0][DATA_W-1:0] shadow_q, shadow_d, shifted;
  logic [L-1:0][DATA_W-1:0] active_q, active_d;
  logic                     err_q, err_d;
  logic                     cp_q;
  mode_e                    m;
  logic                     shift_acc, commit_ok, clear;

  assign m         = mode_e'(mode);
  assign shift_acc = (m == MODE_SHIFT)  && in_valid && in_ready;
  assign commit_ok = (m == MODE_COMMIT) && load_done;
  assign clear     = (m == MODE_CLEAR);

  param_frame_counter #(.L(L), .CNT_W(CNT_W)) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .inc_i       (shift_acc),
    .clr_i       (commit_ok || clear),
    .load_done_o (load_done),
    .in_ready_o  (in_ready)
  );

  // New words enter at the top slot and walk down toward slot 0.
  for (genvar k = 0; k < L; k++) begin : g_shift
    if (k < L - 1) begin : g_mid
      assign shifted[k] = shadow_q[k+1];
    end else begin : g_top
      assign shifted[k] = data_in;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (clear)          shadow_d = '0;
    else if (shift_acc) shadow_d = shifted;

    active_d = commit_ok ? shadow_q : active_q;

    err_d = err_q;
    if (clear)                                                 err_d = 1'b0;
    else if ((m == MODE_SHIFT && in_valid && !in_ready) ||
             (m == MODE_COMMIT && !load_done))                 err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
      cp_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
      cp_q     <= commit_ok;
    end
  end

  assign params_o     = active_q;
  assign err          = err_q;
  assign commit_pulse = cp_q;

`ifdef PARAM_READBACK_EN
  logic [DATA_W-1:0] rb_data_q;
  logic              rb_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= shift_acc;
      if (shift_acc) rb_data_q <= shadow_q[0];
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif

endmodule
